// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 flash responder with read, program, status and write-enable commands
module spi_flash_responder #(
  parameter int          ADDR_W   = 8,
  parameter logic [7:0]  MEM_INIT = 8'hFF
) (
  input  logic p_clk,
  input  logic rst,
  input  logic s_clk,
  input  logic s_css,
  input  logic s_mosi,
  output logic s_miso,
  output logic wel
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD, WR, STAT, IGNORE} state_t;
  state_t r_state, w_next;
  logic [2:0] r_sclk, r_css, r_mosi;
  logic [4:0] r_cnt;
  logic [6:0] r_shift;
  logic [ADDR_W-1:0] r_addr;
  logic r_miso, r_wel, r_op_wr, r_wrote;
  logic [1:0] r_pend;
  logic [7:0] r_mem [2**ADDR_W] = '{default: MEM_INIT};
  logic w_css_fall, w_css_rise, w_rise, w_fall, w_bit, w_last8, w_addr_done, w_we;
  logic [7:0] w_byte, w_status, w_rd_byte;
  assign w_css_fall  = r_css[2] & ~r_css[1];
  assign w_css_rise  = ~r_css[2] & r_css[1];
  // chip-select edges win over a coincident serial-clock edge
  assign w_rise      = r_sclk[1] & ~r_sclk[2] & ~r_css[1] & ~w_css_fall & ~w_css_rise;
  assign w_fall      = ~r_sclk[1] & r_sclk[2] & ~r_css[1] & ~w_css_fall & ~w_css_rise;
  assign w_bit       = r_mosi[2];
  assign w_byte      = {r_shift, w_bit};
  assign w_last8     = r_cnt[2:0] == 3'd7;
  assign w_addr_done = r_cnt == 5'd23;
  assign w_status    = {6'b0, r_wel, 1'b0};
  assign w_rd_byte   = r_mem[r_addr];
  assign w_we        = ~rst & w_rise & (r_state == WR) & w_last8;
  assign s_miso      = r_miso;
  assign wel         = r_wel;
  always_ff @(posedge p_clk) begin
    if (rst) begin
      r_sclk <= 3'b000;
      r_css  <= 3'b111;
      r_mosi <= 3'b000;
    end else begin
      r_sclk <= {r_sclk[1:0], s_clk};
      r_css  <= {r_css[1:0], s_css};
      r_mosi <= {r_mosi[1:0], s_mosi};
    end
  end
  always_ff @(posedge p_clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_css_fall) w_next = CMD;
      CMD:     if (w_rise && w_last8)
                 w_next = (w_byte == 8'h03 || w_byte == 8'h02) ? ADDR : (w_byte == 8'h05) ? STAT : IGNORE;
      ADDR:    if (w_rise && w_addr_done) w_next = !r_op_wr ? RD : r_wel ? WR : IGNORE;
      default: ;
    endcase
    if (w_css_rise) w_next = IDLE;
  end
  always_ff @(posedge p_clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_addr  <= '0;
      r_miso  <= 1'b0;
      r_wel   <= 1'b0;
      r_op_wr <= 1'b0;
      r_pend  <= 2'd0;
      r_wrote <= 1'b0;
    end else if (w_css_rise) begin
      r_miso  <= 1'b0;
      r_cnt   <= '0;
      r_wel   <= (r_pend == 2'd1) ? 1'b1 : (r_pend == 2'd2 || r_wrote) ? 1'b0 : r_wel;
      r_pend  <= 2'd0;
      r_wrote <= 1'b0;
    end else begin
      if (r_state == IDLE && w_css_fall) begin
        r_cnt   <= '0;
        r_pend  <= 2'd0;
        r_wrote <= 1'b0;
      end
      if (w_rise && r_state == CMD) begin
        r_shift <= w_byte[6:0];
        r_cnt   <= w_last8 ? 5'd0 : r_cnt + 5'd1;
        if (w_last8) begin
          r_op_wr <= w_byte == 8'h02;
          r_pend  <= (w_byte == 8'h06) ? 2'd1 : (w_byte == 8'h04) ? 2'd2 : 2'd0;
        end
      end
      if (w_rise && r_state == ADDR) begin
        r_addr <= {r_addr[ADDR_W-2:0], w_bit};
        r_cnt  <= w_addr_done ? 5'd0 : r_cnt + 5'd1;
        if (w_addr_done && r_op_wr && r_wel) r_wrote <= 1'b1;
      end
      if (w_rise && r_state == WR) begin
        r_shift <= w_byte[6:0];
        r_cnt   <= {2'b0, r_cnt[2:0] + 3'd1};
        if (w_last8) r_addr <= r_addr + 1'b1;
      end
      // any bit after WREN/WRDI disqualifies the pending action
      if (w_rise && r_state == IGNORE) r_pend <= 2'd0;
      if (w_fall && r_state == RD) begin
        r_miso <= w_rd_byte[~r_cnt[2:0]];
        r_cnt  <= {2'b0, r_cnt[2:0] + 3'd1};
        if (w_last8) r_addr <= r_addr + 1'b1;
      end
      if (w_fall && r_state == STAT) begin
        r_miso <= w_status[~r_cnt[2:0]];
        r_cnt  <= {2'b0, r_cnt[2:0] + 3'd1};
      end
    end
  end
  always_ff @(posedge p_clk) if (w_we) r_mem[r_addr] <= w_byte;
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed and randomized SPI transactions checked against a byte-level flash model
module tb_spi_flash_responder;
  logic p_clk = 1'b0, rst = 1'b1, s_clk = 1'b0, s_css = 1'b1, s_mosi = 1'b0;
  logic s_miso, wel;
  int n_tests = 0, n_fail = 0;
  logic [7:0] m_mem [256];
  logic m_wel;
  logic [7:0] tx_q[$], rx_q[$], exp_q[$];

  spi_flash_responder dut (
    .p_clk(p_clk), .rst(rst), .s_clk(s_clk), .s_css(s_css),
    .s_mosi(s_mosi), .s_miso(s_miso), .wel(wel)
  );

  always #5 p_clk = ~p_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge p_clk);
    #1;
  endtask

  task automatic run_txn(input int nbits, input int rst_at);
    logic [7:0] rb, t;
    rb = 8'h00;
    rx_q.delete();
    while (tx_q.size() * 8 < nbits) tx_q.push_back(8'($urandom));
    cyc(2);
    s_css = 1'b0;
    cyc(6);
    for (int b = 0; b <= nbits; b++) begin
      if (b == rst_at) begin
        rst = 1'b1;
        cyc(1);
        check("rst_miso", s_miso, 0);
        check("rst_wel", wel, 0);
        rst = 1'b0;
      end
      if (b == nbits) break;
      t = tx_q[b/8];
      s_mosi = t[7 - b%8];
      cyc($urandom_range(5, 8));
      rb = {rb[6:0], s_miso};
      s_clk = 1'b1;
      cyc($urandom_range(5, 8));
      s_clk = 1'b0;
      if (b % 8 == 7) rx_q.push_back(rb);
    end
    cyc($urandom_range(5, 8));
    s_css = 1'b1;
    s_mosi = 1'b0;
    cyc(8);
  endtask

  task automatic model(input int nbits);
    logic [7:0] op, a, ai;
    int nbytes;
    nbytes = nbits / 8;
    exp_q.delete();
    for (int k = 0; k < nbytes; k++) exp_q.push_back(8'h00);
    if (nbits < 8) return;
    op = tx_q[0];
    a = (tx_q.size() > 3) ? tx_q[3] : 8'h00;
    if (op == 8'h03 && nbits >= 32)
      for (int k = 4; k < nbytes; k++) begin
        ai = a + 8'(k - 4);
        exp_q[k] = m_mem[ai];
      end
    if (op == 8'h02 && nbits >= 32 && m_wel) begin
      for (int k = 4; k < nbytes; k++) begin
        ai = a + 8'(k - 4);
        m_mem[ai] = tx_q[k];
      end
      m_wel = 1'b0;
    end
    if (op == 8'h05)
      for (int k = 1; k < nbytes; k++) exp_q[k] = {6'b0, m_wel, 1'b0};
    if (op == 8'h06 && nbits == 8) m_wel = 1'b1;
    if (op == 8'h04 && nbits == 8) m_wel = 1'b0;
  endtask

  task automatic do_txn(input string tag, input int nbits);
    model(nbits);
    run_txn(nbits, -1);
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("%s_b%0d", tag, k), rx_q[k], exp_q[k]);
    check({tag, "_wel"}, wel, m_wel);
    check({tag, "_idle_miso"}, s_miso, 0);
  endtask

  task automatic send(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                      input logic [7:0] b5, input logic [7:0] b6, input int nbits);
    tx_q = '{b0, b1, b2, b3, b4, b5, b6};
    do_txn(tag, nbits);
  endtask

  initial begin
    logic [7:0] op;
    int nb;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'hFF;
    m_wel = 1'b0;
    cyc(4);
    check("reset_miso", s_miso, 0);
    check("reset_wel", wel, 0);
    rst = 1'b0;
    cyc(4);
    send("rd_fresh", 8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 48);
    send("wren1", 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8);
    send("prog_wrap", 8'h02, 8'h00, 8'h00, 8'hFE, 8'hA5, 8'h5A, 8'h3C, 56);
    send("rd_wrap", 8'h03, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 56);
    send("prog_nowel", 8'h02, 8'h00, 8'h00, 8'h20, 8'h12, 8'h00, 8'h00, 40);
    send("rd_20", 8'h03, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 40);
    send("wren2", 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8);
    send("stat_wel1", 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 24);
    send("wrdi", 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8);
    send("stat_wel0", 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 24);
    send("wren3", 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8);
    send("prog_abort", 8'h02, 8'h00, 8'h00, 8'h30, 8'h77, 8'h00, 8'h00, 36);
    send("rd_30", 8'h03, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 40);
    send("wren_long", 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16);
    send("wren4", 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8);
    tx_q = '{8'h03, 8'h00, 8'h00, 8'h40};
    run_txn(16, 16);
    m_wel = 1'b0;
    check("post_rst_wel", wel, 0);
    send("stat_after_rst", 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 24);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: op = 8'h03;
        1: op = 8'h02;
        2: op = 8'h05;
        3: op = 8'h06;
        4: op = 8'h04;
        default: op = 8'($urandom);
      endcase
      nb = 8 * $urandom_range(1, 7);
      if ($urandom_range(0, 3) == 0) nb += $urandom_range(1, 7);
      if ((op == 8'h06 || op == 8'h04) && $urandom_range(0, 1) == 1) nb = 8;
      if ((op == 8'h02 || op == 8'h03) && $urandom_range(0, 2) != 0) nb = 32 + 8 * $urandom_range(1, 3);
      tx_q = '{op};
      repeat (6) tx_q.push_back(8'($urandom));
      do_txn($sformatf("rnd%0d_op%02h", i, op), nb);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
